// File: rtl/i2c_seq_pkg.sv
// Shared constants and state encoding for the I2C register-transaction sequencer.
package i2c_seq_pkg;

    localparam int NREQ_DEF    = 2;
    localparam int TIMEOUT_DEF = 1_200_000;
    localparam int DEV_W       = 7;
    localparam int BYTE_W      = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GRANT = 3'd1,
        S_BYTE1 = 3'd2,
        S_BYTE2 = 3'd3,
        S_DONE  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/i2c_seq_arbiter_if.sv
// Requester-side and I2C-master-side signal bundle for i2c_seq_arbiter.
interface i2c_seq_arbiter_if import i2c_seq_pkg::*; #(
    parameter int NREQ = NREQ_DEF
);

    logic [NREQ-1:0]        req_valid;
    logic [DEV_W*NREQ-1:0]  req_dev;
    logic [NREQ-1:0]        req_rw;
    logic [BYTE_W*NREQ-1:0] req_reg;
    logic [BYTE_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]        req_grant;
    logic [NREQ-1:0]        rsp_valid;
    logic [BYTE_W-1:0]      rsp_rdata;
    logic                   rsp_err;

    logic                   m_enable;
    logic [DEV_W-1:0]       m_addr;
    logic                   m_rw;
    logic [BYTE_W-1:0]      m_data_wr;
    logic [BYTE_W-1:0]      m_data_rd;
    logic                   m_ready;
    logic                   m_busy;
    logic                   m_ack_error;

    // The sequencer side drives grants, responses and the master handshake.
    modport master (
        input  req_valid, req_dev, req_rw, req_reg, req_wdata,
        input  m_data_rd, m_ready, m_busy, m_ack_error,
        output req_grant, rsp_valid, rsp_rdata, rsp_err,
        output m_enable, m_addr, m_rw, m_data_wr
    );

    modport slave (
        output req_valid, req_dev, req_rw, req_reg, req_wdata,
        output m_data_rd, m_ready, m_busy, m_ack_error,
        input  req_grant, rsp_valid, rsp_rdata, rsp_err,
        input  m_enable, m_addr, m_rw, m_data_wr
    );

endinterface

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner.
module i2c_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [$clog2(NREQ)-1:0] win,
    output logic                    any
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_seq_arbiter.sv
// Shares one I2C byte master between NREQ requesters, running pointer-write + write/read per grant.
// Optional watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_seq_arbiter import i2c_seq_pkg::*; #(
    parameter int NREQ           = NREQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    i2c_seq_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("i2c_seq_arbiter: NREQ must be 2..4 and TIMEOUT_CYCLES positive");
    end

    state_t            state, state_nx;
    logic [IDX_W-1:0]  last_q, win, win_q;
    logic              any, busy_q, rise, fall, timeout;
    logic [DEV_W-1:0]  dev_q;
    logic              rw_q, err_q;
    logic [BYTE_W-1:0] reg_q, wdata_q, rdata_q;

    i2c_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req  (bus.req_valid),
        .last (last_q),
        .win  (win),
        .any  (any)
    );

    assign rise = bus.m_busy & ~busy_q;
    assign fall = ~bus.m_busy & busy_q;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [31:0] wdog_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wdog_q <= '0;
        else if (state == S_IDLE) wdog_q <= '0;
        else                      wdog_q <= wdog_q + 32'd1;
    end

    // Fires on the cycle whose successor is the limit, so RESP lands exactly at GRANT+TIMEOUT_CYCLES.
    assign timeout = (state != S_IDLE) && (state != S_RESP) &&
                     (wdog_q >= 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            last_q <= IDX_W'(NREQ - 1);
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= bus.m_busy;
            if (state == S_RESP) last_q <= win_q;
        end
    end

    // Payload is tracked every IDLE cycle; only the value at the IDLE->GRANT edge is ever used.
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            win_q   <= win;
            dev_q   <= bus.req_dev[DEV_W*win +: DEV_W];
            rw_q    <= bus.req_rw[win];
            reg_q   <= bus.req_reg[BYTE_W*win +: BYTE_W];
            wdata_q <= bus.req_wdata[BYTE_W*win +: BYTE_W];
        end
        if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end else if (state == S_DONE && fall) begin
            rdata_q <= rw_q ? bus.m_data_rd : '0;
            err_q   <= bus.m_ack_error;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any && bus.m_ready && !bus.m_busy) state_nx = S_GRANT;
            S_GRANT: state_nx = S_BYTE1;
            S_BYTE1: if (rise) state_nx = S_BYTE2;
            S_BYTE2: if (rise) state_nx = S_DONE;
            S_DONE:  if (fall) state_nx = S_RESP;
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (timeout) state_nx = S_RESP;
    end

    // Second byte is presented from BYTE2 onward; the master samples it well after its busy rise.
    always_comb begin
        bus.req_grant = '0;
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.m_enable  = 1'b0;
        bus.m_addr    = '0;
        bus.m_rw      = 1'b0;
        bus.m_data_wr = '0;
        case (state)
            S_GRANT: begin
                bus.req_grant[win_q] = 1'b1;
                bus.m_enable         = 1'b1;
                bus.m_addr           = dev_q;
                bus.m_data_wr        = reg_q;
            end
            S_BYTE1: begin
                bus.m_enable  = 1'b1;
                bus.m_addr    = dev_q;
                bus.m_data_wr = reg_q;
            end
            S_BYTE2, S_DONE: begin
                bus.m_enable  = (state == S_BYTE2);
                bus.m_addr    = dev_q;
                bus.m_rw      = rw_q;
                bus.m_data_wr = rw_q ? reg_q : wdata_q;
            end
            S_RESP: begin
                bus.rsp_valid[win_q] = 1'b1;
                bus.rsp_rdata        = rdata_q;
                bus.rsp_err          = err_q;
            end
            default: ;
        endcase
        if (timeout) bus.m_enable = 1'b0;
    end

endmodule
